// File: rtl/kpyd_pkg.sv
// kpyd_pkg: shared constants for the keypad column scanner.
package kpyd_pkg;

   // Default matrix geometry and the derived key count.
   localparam int KPYD_ROWS = 4;
   localparam int KPYD_COLS = 4;
   localparam int KEYS      = KPYD_ROWS * KPYD_COLS;

   // Scanner FSM state encoding.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

endpackage

// File: rtl/kpyd_sync.sv
// kpyd_sync: parameterized-width two-flop synchronizer with a selectable
// reset value (rows idle high, so the scanner resets it to all ones).
module kpyd_sync
   import kpyd_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two back-to-back flops to settle the asynchronous input.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/kpyd_scanner.sv
// kpyd_scanner: drives keypad columns one at a time, samples the rows into a
// frame buffer and commits the whole frame to press_o at once.
// Optional ghost-key masking is enabled by defining KPYD_GHOST_MASK_EN.
module kpyd_scanner
   import kpyd_pkg::*;
#(
   parameter int ROWS          = KPYD_ROWS,
   parameter int COLS          = KPYD_COLS,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 enable_i,
   input  logic [ROWS-1:0]      row_i,
   output logic [COLS-1:0]      col_o,
   output logic [ROWS*COLS-1:0] press_o,
   output logic                 scan_done_o,
   output logic                 ghost_o
);

   localparam int NKEYS = ROWS * COLS;
   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic [ROWS-1:0]  row_sync;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [COL_W-1:0] cidx_q, cidx_d;
   logic [NKEYS-1:0] frame_q, frame_d;
   logic [NKEYS-1:0] press_q, press_d;
   logic [COLS-1:0]  col_q, col_d;
   logic             done_q, done_d;
   logic             ghost_q, ghost_d;
   logic             frame_ghost;

   kpyd_sync #(
      .WIDTH   (ROWS),
      .RST_VAL ({ROWS{1'b1}})
   ) u_row_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (row_i),
      .q_o       (row_sync)
   );

`ifdef KPYD_GHOST_MASK_EN
   // A rectangle of four pressed keys cannot be told apart from three, so
   // such a frame is unreliable and gets rejected.
   function automatic logic is_ghost(input logic [NKEYS-1:0] f);
      logic g;
      g = 1'b0;
      for (int r1 = 0; r1 < ROWS; r1++)
         for (int r2 = r1 + 1; r2 < ROWS; r2++)
            for (int c1 = 0; c1 < COLS; c1++)
               for (int c2 = c1 + 1; c2 < COLS; c2++)
                  if (f[r1*COLS+c1] && f[r1*COLS+c2] &&
                      f[r2*COLS+c1] && f[r2*COLS+c2])
                     g = 1'b1;
      return g;
   endfunction

   assign frame_ghost = is_ghost(frame_q);
`else
   assign frame_ghost = 1'b0;
`endif

   // Next-state logic: scan sequencing, frame capture and commit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cidx_d  = cidx_q;
      frame_d = frame_q;
      press_d = press_q;
      done_d  = 1'b0;
      ghost_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d = ST_DRIVE;
               cidx_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_SAMPLE: begin
            for (int r = 0; r < ROWS; r++)
               frame_d[r*COLS + int'(cidx_q)] = ~row_sync[r];
            if (cidx_q == COL_LAST) begin
               state_d = ST_COMMIT;
            end else begin
               state_d = ST_DRIVE;
               cidx_d  = cidx_q + 1'b1;
               cnt_d   = '0;
            end
         end
         default: begin
            done_d  = 1'b1;
            ghost_d = frame_ghost;
            if (!frame_ghost) press_d = frame_q;
            if (enable_i) begin
               state_d = ST_DRIVE;
               cidx_d  = '0;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
      // Column drive follows the next state so it is glitch-free from a flop.
      col_d = '1;
      if (state_d == ST_DRIVE || state_d == ST_SAMPLE) col_d[cidx_d] = 1'b0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cidx_q  <= '0;
         frame_q <= '0;
         press_q <= '0;
         col_q   <= '1;
         done_q  <= 1'b0;
         ghost_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cidx_q  <= cidx_d;
         frame_q <= frame_d;
         press_q <= press_d;
         col_q   <= col_d;
         done_q  <= done_d;
         ghost_q <= ghost_d;
      end
   end

   assign col_o       = col_q;
   assign press_o     = press_q;
   assign scan_done_o = done_q;
   assign ghost_o     = ghost_q;

endmodule

// File: tb/tb_kpyd_scanner.sv
// tb_kpyd_scanner: directed scan of a 4x4 keypad model with a frame
// scoreboard of expected {ghost, press} values.
module tb_kpyd_scanner;

   localparam int R = 4;
   localparam int C = 4;
   localparam int S = 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          enable_i;
   logic [R-1:0]  row_i;
   logic [C-1:0]  col_o;
   logic [15:0]   press_o;
   logic          scan_done_o;
   logic          ghost_o;

   logic [15:0]   keys;
   logic [3:0]    ecol;
   logic [16:0]   exp_q[$];
   int            total = 0;
   int            bad   = 0;

   always #5 clk_i = ~clk_i;

   kpyd_scanner #(
      .ROWS          (R),
      .COLS          (C),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .enable_i    (enable_i),
      .row_i       (row_i),
      .col_o       (col_o),
      .press_o     (press_o),
      .scan_done_o (scan_done_o),
      .ghost_o     (ghost_o)
   );

   // Keypad model: a row is pulled low when a pressed key sits in a driven column.
   always_comb begin
      row_i = '1;
      for (int r = 0; r < R; r++)
         row_i[r] = ~|(keys[r*C +: C] & ~col_o);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic g, input logic [15:0] p);
      exp_q.push_back({g, p});
   endtask

   // Wait for the next frame commit, check its spacing and the scoreboard entry.
   task automatic wait_done(input string tag, input int want_cyc);
      int          n;
      logic [16:0] e;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (scan_done_o !== 1'b1 && n < 200);
      chk({tag, " cyc"}, n, want_cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
      chk({tag, " press"}, {16'h0, press_o}, {16'h0, e[15:0]});
      chk({tag, " ghost"}, {31'h0, ghost_o}, {31'h0, e[16]});
   endtask

   initial begin
      keys      = '0;
      reset_n_i = 1'b0;
      enable_i  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst", {col_o, scan_done_o, ghost_o, press_o}, {4'hF, 1'b0, 1'b0, 16'h0});

      // Reset release with enable: column walk, commit gap, frame period.
      reset_n_i = 1'b1;
      enable_i  = 1'b1;
      for (int i = 0; i < 4 * (S + 1); i++) begin
         @(negedge clk_i);
         ecol = ~(4'b0001 << (i / (S + 1)));
         chk("t1 col", {28'h0, col_o}, {28'h0, ecol});
      end
      @(negedge clk_i);
      chk("t1 commit col", {col_o, scan_done_o}, {4'hF, 1'b0});
      push(1'b0, 16'h0000);
      wait_done("t1 first", 1);
      push(1'b0, 16'h0000);
      wait_done("t1 period", 21);

      // Single key (2,1), then release.
      keys = 16'h0200;
      push(1'b0, 16'h0200);
      wait_done("t2 press", 21);
      keys = 16'h0000;
      push(1'b0, 16'h0000);
      wait_done("t2 release", 21);

      // Two keys on a diagonal: not a ghost pattern.
      keys = 16'h8001;
      push(1'b0, 16'h8001);
      wait_done("t6 diag", 21);

      // Rectangle of four keys.
      keys = 16'h0033;
`ifdef KPYD_GHOST_MASK_EN
      push(1'b1, 16'h8001);
`else
      push(1'b0, 16'h0033);
`endif
      wait_done("t5 rect", 21);
      keys = 16'h0000;
      push(1'b0, 16'h0000);
      wait_done("t5 clear", 21);

      // Enable dropped during column 2: frame finishes, then idle.
      keys = 16'h0200;
      push(1'b0, 16'h0200);
      repeat (11) @(negedge clk_i);
      chk("t3 col2", {28'h0, col_o}, 32'hB);
      enable_i = 1'b0;
      wait_done("t3 last", 10);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         chk("t3 idle", {col_o, scan_done_o, press_o}, {4'hF, 1'b0, 16'h0200});
      end

      // Reset during column 3 with key (0,0) held, then restart.
      keys     = 16'h0001;
      enable_i = 1'b1;
      repeat (17) @(negedge clk_i);
      chk("t4 col3", {28'h0, col_o}, 32'h7);
      reset_n_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("t4 rst", {col_o, scan_done_o, ghost_o, press_o}, {4'hF, 1'b0, 1'b0, 16'h0});
      end
      reset_n_i = 1'b1;
      push(1'b0, 16'h0001);
      wait_done("t4 restart", 22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/kpyd_scanner.md
# kpyd_scanner

Matrix keypad column scanner that drives the keypad columns one at a time, samples the row lines and assembles a per-key raw press vector. It sits directly upstream of the per-key debouncers: each bit of `press_o` feeds one debouncer's `press_i`. Frames are committed atomically, so downstream logic never sees a half-scanned matrix. Optional ghost-key masking suppresses frames with an impossible press pattern.

## Interface
- `ROWS`, default 4: number of row lines (inputs).
- `COLS`, default 4: number of column lines (outputs).
- `SETTLE_CYCLES`, default 8: cycles a column is driven before sampling; must be ≥ 3.
- `clk_i` in 1: the block's only clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `enable_i` in 1: run scanning; sampled at frame boundaries only.
- `row_i` in ROWS: keypad rows, pulled up, asynchronous; low means a key in the driven column is pressed.
- `col_o` out COLS: column drive, active-low; at most one bit low at a time.
- `press_o` out ROWS*COLS: raw press vector, bit `r*COLS+c` = key at row r, column c.
- `scan_done_o` out 1: one-cycle pulse when a frame completes.
- `ghost_o` out 1: one-cycle pulse when a completed frame was rejected as ghosted.

## Operation
- `row_i` passes through a 2-flop synchronizer before use.
- FSM states:
  - IDLE: `col_o='1`. Moves to DRIVE at column 0 when `enable_i=1`.
  - DRIVE: column c is driven low and a settle counter runs 0..SETTLE_CYCLES-1. On the last count, moves to SAMPLE.
  - SAMPLE (1 cycle): stores `~row_sync` into frame buffer bits for column c.
    - If c < COLS-1: next state is DRIVE with c+1 and the counter cleared.
    - If c = COLS-1: next state is COMMIT.
  - COMMIT (1 cycle): `col_o='1` and the frame is evaluated.
    - `press_o` is loaded from the frame buffer, unless the frame is ghost-rejected.
    - `scan_done_o=1` for this cycle.
    - Next state is DRIVE at column 0 if `enable_i=1`, otherwise IDLE.
- Deasserting `enable_i` mid-frame does not abort: the current frame completes and commits, then the FSM goes to IDLE.
- `press_o` holds its last committed value in IDLE and throughout a frame.
- Column index wraps from COLS-1 to 0 only through COMMIT.
- Settle counter width is `$clog2(SETTLE_CYCLES)`. Column index width is `$clog2(COLS)`, minimum 1.
- Reset mid-frame: the frame buffer is discarded and all outputs return to reset values on the next edge.

## Timing
- Reset values: `col_o='1`, `press_o='0`, `scan_done_o=0`, `ghost_o=0`, state IDLE, frame buffer `'0`.
- First cycle after reset release with `enable_i=1`: state moves to DRIVE, and `col_o` shows column 0 low from the following cycle.
- Each column occupies SETTLE_CYCLES+1 cycles. A frame occupies COLS*(SETTLE_CYCLES+1)+1 cycles including COMMIT.
- Synchronizer latency is 2 cycles, which is less than SETTLE_CYCLES. The sample therefore reflects rows as they stood while the current column was driven.
- `press_o` changes on the same edge that asserts `scan_done_o`.
- A row change takes at most 2 frames plus 2 cycles to reach `press_o`.

## Configuration
- Macro: `KPYD_GHOST_MASK_EN`.
- Defined:
  - At COMMIT, if any r1≠r2 and c1≠c2 have all four keys (r1,c1), (r1,c2), (r2,c1), (r2,c2) pressed, the frame is ghosted.
  - For a ghosted frame, `press_o` keeps its previous value and `ghost_o` pulses together with `scan_done_o`.
- Undefined: every frame commits and `ghost_o` is tied 0.

## Structure
- Package `kpyd_pkg` holds:
  - the FSM state enum (IDLE, DRIVE, SAMPLE, COMMIT);
  - default `ROWS`/`COLS` constants;
  - a key-index helper constant, `KEYS = ROWS*COLS`.
- Sub-module `kpyd_sync`: a parameterized-width 2-flop synchronizer, instantiated on `row_i`.
- The ghost check is a combinational function over the frame buffer inside the scanner.

## Test plan
All scenarios use ROWS=COLS=4, SETTLE_CYCLES=4, so each column takes 5 cycles and a frame takes 21 cycles.

1. Reset and enable:
   - Stimulus: hold `reset_n_i=0` for 3 cycles, then release with `enable_i=1`.
   - Required: `col_o` steps 1110→1101→1011→0111, 5 cycles each; `scan_done_o` pulses every 21 cycles; `press_o=0`.
2. Single key:
   - Stimulus: model key (2,1), so `row_i[2]` is low while `col_o[1]` is low.
   - Required: after the next COMMIT, `press_o=16'h0200`; after release, `press_o` returns to 0 by the second subsequent COMMIT.
3. Enable dropped mid-frame:
   - Stimulus: `enable_i=0` during column 2.
   - Required: columns 2 and 3 complete; `scan_done_o` pulses once; then `col_o=4'hF` held and `press_o` stable.
4. Reset mid-frame:
   - Stimulus: assert reset during column 3 with key (0,0) pressed.
   - Required: next edge gives `col_o=4'hF`, `press_o=0`, no `scan_done_o`.
5. Ghost, with `KPYD_GHOST_MASK_EN`:
   - Stimulus: press keys (0,0), (0,1), (1,0), (1,1).
   - Required: `ghost_o` and `scan_done_o` pulse together; `press_o` keeps the prior value.
   - Without the macro: `press_o=16'h0033` and `ghost_o=0`.
6. Multiple non-ghost keys:
   - Stimulus: press keys (0,0) and (3,3).
   - Required: `press_o=16'h8001`, `ghost_o=0`.
